// File: rtl/vga_sync_monitor.sv
// VGA sync/colour receive checker: measures line and frame timing,
// declares lock after conforming frames and flags sticky errors.
module vga_sync_monitor #(
   parameter int CNT_W       = 12,
   parameter int LINE_W      = 11,
   parameter int H_TOTAL     = 1600,
   parameter int H_START     = 288,
   parameter int H_DISP      = 1280,
   parameter int V_TOTAL     = 480,
   parameter int V_START     = 29,
   parameter int V_DISP      = 450,
   parameter int TOL         = 4,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iHsync,
   input  logic              iVsync,
   input  logic              iRed,
   input  logic              iGreen,
   input  logic              iBlue,
   input  logic              iClearErr,
   output logic              oLocked,
   output logic [CNT_W-1:0]  oLineLen,
   output logic [LINE_W-1:0] oFrameLines,
   output logic [CNT_W-1:0]  oHPos,
   output logic [LINE_W-1:0] oVLine,
   output logic              oDisplay,
   output logic              oSyncErr,
   output logic              oColorErr
);

   localparam int GW = $clog2(LOCK_FRAMES + 1);

   localparam logic [CNT_W-1:0]  H_MAX  = '1;
   localparam logic [LINE_W-1:0] V_MAX  = '1;
   localparam logic [CNT_W:0]    LEN_LO = (CNT_W+1)'(H_TOTAL - TOL);
   localparam logic [CNT_W:0]    LEN_HI = (CNT_W+1)'(H_TOTAL + TOL);
   localparam logic [CNT_W-1:0]  H_LO   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0]  H_HI   = CNT_W'(H_START + H_DISP);
   localparam logic [LINE_W-1:0] V_LO   = LINE_W'(V_START);
   localparam logic [LINE_W-1:0] V_HI   = LINE_W'(V_START + V_DISP);
   localparam logic [LINE_W-1:0] V_TOT  = LINE_W'(V_TOTAL);
   localparam logic [GW-1:0]     LOCK_N = GW'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEARCH,
      MEASURE,
      LOCKED
   } state_t;

   state_t state, state_nx;

   logic [4:0]        sync1, sync2;
   logic              hs_d, vs_d;
   logic              hfall, vfall, col_any;
   logic [CNT_W-1:0]  h_cnt, len_nx;
   logic [CNT_W:0]    len_ext;
   logic [LINE_W-1:0] v_cnt;
   logic              h_sat, waive, line_ok, line_bad;
   logic              frame_bad, fbad_nx, frame_ok;
   logic [GW-1:0]     good, good_nx, good_inc;
   logic              sync_set, color_set;

   // Syncs idle high, so reset them high to avoid a false first edge
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1 <= 5'b11000;
         sync2 <= 5'b11000;
         hs_d  <= 1'b1;
         vs_d  <= 1'b1;
      end else begin
         sync1 <= {iHsync, iVsync, iRed, iGreen, iBlue};
         sync2 <= sync1;
         hs_d  <= sync2[4];
         vs_d  <= sync2[3];
      end
   end

   assign hfall   = hs_d & ~sync2[4];
   assign vfall   = vs_d & ~sync2[3];
   assign col_any = |sync2[2:0];

   assign h_sat    = (h_cnt == H_MAX);
   assign len_nx   = h_sat ? H_MAX : h_cnt + CNT_W'(1);
   assign len_ext  = {1'b0, len_nx};
   assign line_ok  = (len_ext >= LEN_LO) && (len_ext <= LEN_HI);
   assign line_bad = hfall && !vfall && !waive && !line_ok;
   assign frame_ok = !frame_bad && (v_cnt == V_TOT);
   assign good_inc = good + GW'(1);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         h_cnt    <= '1;
         oLineLen <= '0;
         waive    <= 1'b1;
      end else begin
         if (hfall) begin
            h_cnt    <= '0;
            oLineLen <= len_nx;
         end else if (!h_sat) begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
         // Next hfall is unchecked after vsync or a stalled line
         if (vfall)
            waive <= 1'b1;
         else if (hfall)
            waive <= 1'b0;
         else if (h_sat)
            waive <= 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         v_cnt       <= '0;
         oFrameLines <= '0;
      end else if (vfall) begin
         oFrameLines <= v_cnt;
         v_cnt       <= '0;
      end else if (hfall && v_cnt != V_MAX) begin
         v_cnt <= v_cnt + LINE_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      good_nx  = good;
      fbad_nx  = frame_bad;
      sync_set = 1'b0;
      unique case (state)
         SEARCH: begin
            if (vfall) begin
               state_nx = MEASURE;
               good_nx  = '0;
               fbad_nx  = 1'b0;
            end
         end
         MEASURE: begin
            if (line_bad)
               fbad_nx = 1'b1;
            if (vfall) begin
               fbad_nx = 1'b0;
               if (frame_ok) begin
                  good_nx = good_inc;
                  if (good_inc == LOCK_N)
                     state_nx = LOCKED;
               end else begin
                  good_nx = '0;
               end
            end
         end
         LOCKED: begin
            if (line_bad || (vfall && v_cnt != V_TOT)) begin
               state_nx = SEARCH;
               sync_set = 1'b1;
            end
         end
         default: state_nx = SEARCH;
      endcase
      if (h_sat) begin
         state_nx = SEARCH;
         good_nx  = '0;
         if (state == LOCKED)
            sync_set = 1'b1;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state     <= SEARCH;
         good      <= '0;
         frame_bad <= 1'b0;
      end else begin
         state     <= state_nx;
         good      <= good_nx;
         frame_bad <= fbad_nx;
      end
   end

   assign oLocked  = (state == LOCKED);
   assign oHPos    = h_cnt;
   assign oVLine   = v_cnt;
   assign oDisplay = oLocked &&
                     (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                     (v_cnt >= V_LO) && (v_cnt < V_HI);

   assign color_set = oLocked && !oDisplay && col_any;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         oSyncErr  <= 1'b0;
         oColorErr <= 1'b0;
      end else begin
         if (sync_set)
            oSyncErr <= 1'b1;
         else if (iClearErr)
            oSyncErr <= 1'b0;
         if (color_set)
            oColorErr <= 1'b1;
         else if (iClearErr)
            oColorErr <= 1'b0;
      end
   end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the VGA sync/colour outputs produced by the display timing generator. It samples Hsync, Vsync and the three colour bits in the system clock domain and measures line length and lines per frame. It declares lock after consecutive conforming frames and reports the current beam position plus sticky error flags. It sits on the board-test and simulation path, wired in parallel with the VGA connector pins.

## Interface
- CNT_W, 12, width of clock-per-line counter and oHPos/oLineLen
- LINE_W, 11, width of line counter and oVLine/oFrameLines
- H_TOTAL, 1600, expected clocks between consecutive Hsync falling edges
- H_START, 288, first display clock after Hsync fall (PW+BP)
- H_DISP, 1280, display clocks per line
- V_TOTAL, 480, expected Hsync falls per frame (Vsync fall to Vsync fall)
- V_START, 29, first display line index after Vsync fall
- V_DISP, 450, display lines per frame
- TOL, 4, allowed |measured − H_TOTAL| in clocks
- LOCK_FRAMES, 2, consecutive good frames required for lock
- Clock  in  1  system clock, all logic on posedge
- Reset  in  1  asynchronous, active-low; clears all state
- iHsync  in  1  horizontal sync, active-low pulse
- iVsync  in  1  vertical sync, active-low pulse
- iRed, iGreen, iBlue  in  1 each  colour bits
- iClearErr  in  1  synchronous clear of sticky flags
- oLocked  out  1  timing conforms
- oLineLen  out  CNT_W  last measured line length (clocks)
- oFrameLines  out  LINE_W  last measured lines per frame
- oHPos  out  CNT_W  clocks since last Hsync fall
- oVLine  out  LINE_W  Hsync falls since last Vsync fall
- oDisplay  out  1  locked and inside active window
- oSyncErr  out  1  sticky: lock lost
- oColorErr  out  1  sticky: colour high outside active window while locked

## Operation
- All five inputs pass through a 2-FF synchronizer; falling edges are detected on the second stage against a delayed copy (hfall, vfall).
- h_cnt: loads 0 on hfall, else increments, saturating at all-ones. Reset value all-ones. oHPos = h_cnt.
- On hfall: oLineLen <= h_cnt + 1 (saturating). Line check is waived for the first hfall after reset, after a saturated h_cnt, and after each vfall (Hsync may pause during vertical sync).
- v_cnt: increments on hfall; on vfall, oFrameLines <= v_cnt and v_cnt <= 0. Simultaneous hfall and vfall: vfall wins, and that hfall is not counted. oVLine = v_cnt. v_cnt saturates.
- FSM states are SEARCH, MEASURE and LOCKED; reset enters SEARCH.
  - SEARCH: on vfall -> MEASURE with good = 0 and frame_bad = 0.
  - MEASURE: a non-waived hfall whose length is out of tolerance sets frame_bad. On vfall, the frame is good if !frame_bad and the counted lines equal V_TOTAL.
    - Good frame: good++. When good reaches LOCK_FRAMES -> LOCKED.
    - Bad frame: good = 0, stay in MEASURE.
    - frame_bad clears on every vfall.
  - LOCKED: a bad line, a bad frame count at vfall, or h_cnt saturating -> SEARCH, and oSyncErr set.
  - Any state: h_cnt saturation -> SEARCH, good = 0.
- oDisplay = LOCKED && H_START <= h_cnt < H_START+H_DISP && V_START <= v_cnt < V_START+V_DISP.
- oColorErr sets when in LOCKED, oDisplay = 0 and any synchronized colour bit = 1.
- iClearErr clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- Reset values: oLocked, oDisplay, oSyncErr, oColorErr = 0. oLineLen = 0, oFrameLines = 0, oHPos = all-ones, oVLine = 0.

## Timing
- Pin change sampled at edge k; hfall/vfall are detected combinationally during cycle k+1 to k+2; registered effects are visible after edge k+2.
- oLineLen, oFrameLines, h_cnt/v_cnt updates and FSM transitions all commit on the same edge (k+2).
- oLocked rises on the edge that commits the LOCK_FRAMES-th good vfall. It falls on the edge that commits the failing hfall or vfall, together with oSyncErr.
- oDisplay is combinational from registered state (0 cycles added).
- Reset assertion mid-frame clears everything immediately. After release, lock needs 1 + LOCK_FRAMES vfalls.

## Test plan
- Bench parameters: H_TOTAL=40, H_START=8, H_DISP=24, V_TOTAL=10, V_START=2, V_DISP=6, TOL=1, LOCK_FRAMES=2.
- Ideal timing, 4 frames -> oLineLen=40, oFrameLines=10, oLocked rises at the 3rd vfall commit, oSyncErr=0.
- One line of 45 clocks in frame 5 while locked -> oLocked falls at that hfall+2, oSyncErr=1, relock after 3 further good vfalls.
- Lines of 41 and 39 clocks (within TOL) -> lock held, oLineLen reports 41 then 39.
- Frame of 9 lines; and hfall coincident with vfall -> that hfall not counted, oFrameLines=9, lock lost / reacquisition per rules.
- Red high at h_cnt=5 while locked -> oColorErr=1. Red high at h_cnt=10, v_cnt=3 -> no error. iClearErr with a simultaneous new violation -> flag stays 1.
- Hsync stuck high for 4096 clocks -> SEARCH, oLocked=0. Reset pulsed mid-line -> all outputs at reset values on the same cycle.
